dmem_arbiter: RTL and testbench

Shares the single-port data memory between the pipelined ARM processor's memory stage and a DMA/loader port. Sits between the processor, the DMA master and `dmem` in the top level. The processor has priority, with two limits: a starvation counter guarantees DMA progress, and a burst cap bounds how long DMA can hold the memory. A CPU request that loses arbitration raises `cpu_stall` for the pipeline.

---
 rtl/arb_pkg.sv | 25 ++
 rtl/sat_counter.sv | 29 ++
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package arb_pkg;

    localparam int ARB_DATA_W    = 32;
    localparam int ARB_ADDR_W    = 32;
    localparam int ARB_MAX_WAIT  = 4;
    localparam int ARB_BURST_MAX = 8;

    typedef enum logic [0:0] {
        CPU_OWN   = 1'b0,
        DMA_BURST = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    // Bits needed to hold a counter that runs 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX_C = W'(MAX);
    localparam logic [W-1:0] ONE_C = W'(1);

    // Count up on inc, hold at MAX, return to zero on clr or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= {W{1'b0}};
        end else if (clr) begin
            cnt <= {W{1'b0}};
        end else if (inc && (cnt != MAX_C)) begin
            cnt <= cnt + ONE_C;
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU memory stage has priority, DMA is
// protected from starvation by a forced beat and bounded by a burst cap.
module dmem_arbiter
    import arb_pkg::*;
#(
    parameter int DATA_W    = ARB_DATA_W,
    parameter int ADDR_W    = ARB_ADDR_W,
    parameter int MAX_WAIT  = ARB_MAX_WAIT,
    parameter int BURST_MAX = ARB_BURST_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_last,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam int SW = cnt_width(MAX_WAIT);
    localparam int BW = cnt_width(BURST_MAX);
    localparam logic [SW-1:0] STARVE_LIMIT_C = SW'(MAX_WAIT);
    localparam logic [BW-1:0] LAST_BEAT_C    = BW'(BURST_MAX - 1);

    arb_state_t    state_r;
    logic [SW-1:0] starve_cnt_r;
    logic [BW-1:0] beat_cnt_r;

    owner_t owner_s;
    logic   burst_start_s;
    logic   burst_end_s;
    logic   cpu_grant_s;
    logic   dma_gnt_s;
    logic   starve_inc_s;
    logic   starve_clr_s;
    logic   beat_inc_s;
    logic   beat_clr_s;

    // Decide the owner of this cycle and whether a burst opens or closes.
    // Reset suppresses every grant so an in-flight burst stops writing at once.
    always_comb begin
        owner_s       = OWN_NONE;
        burst_start_s = 1'b0;
        burst_end_s   = 1'b0;
        if (rst) begin
            owner_s = OWN_NONE;
        end else begin
            case (state_r)
                CPU_OWN: begin
                    if (dma_req && (starve_cnt_r == STARVE_LIMIT_C)) begin
                        owner_s = OWN_DMA;        // forced single beat, no burst
                    end else if (cpu_req) begin
                        owner_s = OWN_CPU;
                    end else if (dma_req) begin
                        owner_s       = OWN_DMA;
                        burst_start_s = !dma_last;
                    end else begin
                        owner_s = OWN_NONE;
                    end
                end
                DMA_BURST: begin
                    if (dma_req) begin
                        owner_s     = OWN_DMA;
                        burst_end_s = dma_last || (beat_cnt_r == LAST_BEAT_C);
                    end else begin
                        owner_s     = OWN_NONE;   // abort: master dropped request
                        burst_end_s = 1'b1;
                    end
                end
                default: begin
                    owner_s = OWN_NONE;
                end
            endcase
        end
    end

    assign cpu_grant_s = (owner_s == OWN_CPU);
    assign dma_gnt_s   = (owner_s == OWN_DMA);

    assign starve_inc_s = dma_req && !dma_gnt_s;
    assign starve_clr_s = dma_gnt_s || !dma_req;
    assign beat_inc_s   = burst_start_s || ((state_r == DMA_BURST) && dma_gnt_s);
    assign beat_clr_s   = burst_end_s;

    // Track consecutive denied DMA cycles.
    sat_counter #(.MAX(MAX_WAIT), .W(SW)) u_starve_cnt (
        .clk (clk),
        .rst (rst),
        .inc (starve_inc_s),
        .clr (starve_clr_s),
        .cnt (starve_cnt_r)
    );

    // Track beats granted in the current burst.
    sat_counter #(.MAX(BURST_MAX), .W(BW)) u_beat_cnt (
        .clk (clk),
        .rst (rst),
        .inc (beat_inc_s),
        .clr (beat_clr_s),
        .cnt (beat_cnt_r)
    );

    // Ownership FSM: enter a burst on a non-last DMA beat, leave on end/cap/abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= CPU_OWN;
        end else begin
            case (state_r)
                CPU_OWN:   state_r <= burst_start_s ? DMA_BURST : CPU_OWN;
                DMA_BURST: state_r <= burst_end_s ? CPU_OWN : DMA_BURST;
                default:   state_r <= CPU_OWN;
            endcase
        end
    end

    // Route the grantee onto the memory port; idle cycles present the CPU side read-only.
    always_comb begin
        mem_addr    = cpu_addr;
        mem_wr_data = cpu_wdata;
        mem_wr_en   = 1'b0;
        case (owner_s)
            OWN_CPU: begin
                mem_addr    = cpu_addr;
                mem_wr_data = cpu_wdata;
                mem_wr_en   = cpu_we;
            end
            OWN_DMA: begin
                mem_addr    = dma_addr;
                mem_wr_data = dma_wdata;
                mem_wr_en   = dma_we;
            end
            default: begin
                mem_addr    = cpu_addr;
                mem_wr_data = cpu_wdata;
                mem_wr_en   = 1'b0;
            end
        endcase
    end

    assign dma_gnt   = dma_gnt_s;
    assign cpu_stall = cpu_req && !cpu_grant_s && !rst;
    assign cpu_rdata = mem_rd_data;
    assign dma_rdata = mem_rd_data;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural single-port memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_last, dma_gnt;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

    logic [31:0] mem [0:255];

    typedef struct {
        string       nm;
        bit          stall;
        bit          gnt;
        bit          we;
        logic [31:0] addr;
        bit          chk_rd;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_W(32), .ADDR_W(32), .MAX_WAIT(4), .BURST_MAX(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_last(dma_last),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
        .dma_rdata(dma_rdata),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    // Behavioural dmem: combinational read, write at the rising edge.
    assign mem_rd_data = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr[9:2]] <= mem_wr_data;
    end

    // Monitor: each cycle with an outstanding expectation, compare at mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks += 4;
            if (cpu_stall !== e.stall) begin
                errors++; $display("FAIL %s cpu_stall got %0b exp %0b", e.nm, cpu_stall, e.stall);
            end
            if (dma_gnt !== e.gnt) begin
                errors++; $display("FAIL %s dma_gnt got %0b exp %0b", e.nm, dma_gnt, e.gnt);
            end
            if (mem_wr_en !== e.we) begin
                errors++; $display("FAIL %s mem_wr_en got %0b exp %0b", e.nm, mem_wr_en, e.we);
            end
            if (mem_addr !== e.addr) begin
                errors++; $display("FAIL %s mem_addr got %h exp %h", e.nm, mem_addr, e.addr);
            end
            if (e.chk_rd) begin
                checks++;
                if (cpu_rdata !== e.rd) begin
                    errors++; $display("FAIL %s cpu_rdata got %h exp %h", e.nm, cpu_rdata, e.rd);
                end
            end
        end
    end

    // Drive one cycle of stimulus and queue its expected response.
    task automatic vec(input string nm,
                       input bit creq, input bit cwe, input logic [31:0] caddr, input logic [31:0] cwd,
                       input bit dreq, input bit dwe, input bit dlast, input logic [31:0] daddr, input logic [31:0] dwd,
                       input bit e_stall, input bit e_gnt, input bit e_we, input logic [31:0] e_addr,
                       input bit chk_rd, input logic [31:0] e_rd, input bit mid_rst);
        exp_t e;
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        dma_req = dreq; dma_we = dwe; dma_last = dlast; dma_addr = daddr; dma_wdata = dwd;
        e.nm = nm; e.stall = e_stall; e.gnt = e_gnt; e.we = e_we; e.addr = e_addr;
        e.chk_rd = chk_rd; e.rd = e_rd;
        if (mid_rst) begin
            #2 rst = 1'b1;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm);
        vec(nm, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    task automatic chk_mem(input string nm, input logic [31:0] addr, input logic [31:0] expv, input bit want_eq);
        logic [31:0] v;
        v = mem[addr[9:2]];
        checks++;
        if ((v === expv) != want_eq) begin
            errors++;
            $display("FAIL %s mem[%h] got %h %s %h", nm, addr, v, want_eq ? "exp" : "must differ from", expv);
        end
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_last = 0; dma_addr = 0; dma_wdata = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset: all grants suppressed, no stall, mux shows CPU address.
        vec("reset", 1, 1, 32'h8, 32'h5, 1, 1, 1, 32'h30, 32'h6, 0, 0, 0, 32'h8, 0, 32'h0, 0);
        rst = 1'b0;

        // Mutual exclusion: CPU wins the tie, DMA next cycle.
        vec("mx_cpu", 1, 1, 32'h10, 32'h11111111, 1, 1, 1, 32'h20, 32'h22222222, 0, 0, 1, 32'h10, 0, 32'h0, 0);
        vec("mx_dma", 0, 0, 32'h10, 32'h0, 1, 1, 1, 32'h20, 32'h22222222, 0, 1, 1, 32'h20, 0, 32'h0, 0);
        chk_mem("mx_cpu_wr", 32'h10, 32'h11111111, 1);
        chk_mem("mx_dma_wr", 32'h20, 32'h22222222, 1);
        idle("idle0");

        // Read path: DMA writes, CPU reads back in the granted cycle.
        vec("rd_dma", 0, 0, 32'h0, 32'h0, 1, 1, 1, 32'h40, 32'hDEADBEEF, 0, 1, 1, 32'h40, 0, 32'h0, 0);
        vec("rd_cpu", 1, 0, 32'h40, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h40, 1, 32'hDEADBEEF, 0);

        // Starvation: denied 4 cycles, forced on the 5th, repeating.
        for (int i = 0; i < 10; i++) begin
            bit forced;
            forced = ((i % 5) == 4);
            vec("starve", 1, 0, 32'h0, 32'h0, 1, 1, 1, 32'h80, 32'h100 + i, forced, forced, forced,
                forced ? 32'h80 : 32'h0, 0, 32'h0, 0);
        end
        idle("idle1");

        // Burst cap: 8 beats, CPU wins cycle 9, DMA resumes and finishes.
        for (int k = 0; k < 8; k++) begin
            vec("cap_beat", 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h100 + 4 * k, 32'hB000 + k, 0, 1, 1, 32'h100 + 4 * k, 0, 32'h0, 0);
        end
        vec("cap_cpu", 1, 0, 32'h104, 32'h0, 1, 1, 0, 32'h120, 32'hB008, 0, 0, 0, 32'h104, 1, 32'h0000B001, 0);
        for (int k = 8; k < 12; k++) begin
            vec("cap_resume", 0, 0, 32'h0, 32'h0, 1, 1, (k == 11), 32'h100 + 4 * k, 32'hB000 + k, 0, 1, 1, 32'h100 + 4 * k, 0, 32'h0, 0);
        end
        chk_mem("cap_last_wr", 32'h12C, 32'h0000B00B, 1);
        vec("cap_own", 1, 0, 32'h8, 32'h0, 1, 1, 0, 32'h130, 32'h1, 0, 0, 0, 32'h8, 0, 32'h0, 0);
        idle("idle2");

        // Abort: three beats, then request drops with write enable still high.
        for (int k = 0; k < 3; k++) begin
            vec("ab_beat", 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h200 + 4 * k, 32'hA000 + k, 0, 1, 1, 32'h200 + 4 * k, 0, 32'h0, 0);
        end
        vec("ab_drop", 0, 0, 32'h4, 32'h0, 0, 1, 0, 32'h20C, 32'hA003, 0, 0, 0, 32'h4, 0, 32'h0, 0);
        vec("ab_own", 1, 0, 32'h4, 32'h0, 1, 1, 0, 32'h20C, 32'hA003, 0, 0, 0, 32'h4, 0, 32'h0, 0);
        idle("idle3");
        // A fresh burst after the abort still gets the full 8 beats.
        for (int k = 0; k < 8; k++) begin
            vec("ab_reburst", 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h240 + 4 * k, 32'hE000 + k, 0, 1, 1, 32'h240 + 4 * k, 0, 32'h0, 0);
        end
        vec("ab_recap", 1, 0, 32'h8, 32'h0, 1, 1, 1, 32'h260, 32'hE008, 0, 0, 0, 32'h8, 0, 32'h0, 0);
        vec("ab_fin", 0, 0, 32'h0, 32'h0, 1, 1, 1, 32'h260, 32'hE008, 0, 1, 1, 32'h260, 0, 32'h0, 0);
        idle("idle4");

        // Async reset asserted mid-cycle during beat 2 of a burst.
        vec("rs_beat1", 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h300, 32'hC0, 0, 1, 1, 32'h300, 0, 32'h0, 0);
        vec("rs_beat2", 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h304, 32'hC1, 0, 0, 0, 32'h0, 0, 32'h0, 1);
        chk_mem("rs_no_wr", 32'h304, 32'h000000C1, 0);
        rst = 1'b0;
        vec("rs_cpu_ld", 1, 0, 32'h300, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h300, 1, 32'h000000C0, 0);
        idle("idle5");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
